// File: rtl/dfx_rp_ctrl.sv
// Swap sequencer for the two LED-counter reconfigurable partitions.
// Owns RP isolation/reset and reports a per-sequence status code.
module dfx_rp_ctrl #(
    parameter int QUIESCE_CYC = 16,
    parameter int RST_CYC     = 8,
    parameter int TO_W        = 24
) (
    input  logic        clk100,
    input  logic        rst,
    input  logic        req_i,
    input  logic        req_sel_i,
    output logic        load_go_o,
    input  logic        load_done_i,
    input  logic        load_err_i,
    output logic [1:0]  decouple_o,
    output logic [1:0]  rp_rst_o,
    input  logic [31:0] version_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  status_o,
    output logic [31:0] last_vers_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECOUPLE, S_LOAD, S_RESET, S_RECOUPLE, S_CHECK
    } state_t;

    localparam int CW = (TO_W > 31) ? TO_W + 1 : 32;
    localparam logic [CW-1:0] Q_LAST  = CW'(QUIESCE_CYC - 1);
    localparam logic [CW-1:0] R_LAST  = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] C_LAST  = CW'(2);
    // Timeout fires on the cycle the count would reach 2^TO_W-1
    localparam logic [CW-1:0] TO_LAST =
        {{(CW-TO_W){1'b0}}, {TO_W{1'b1}}} - CW'(1);

    state_t        state, state_d;
    logic          sel, sel_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    dec_d, rprst_d, status_d;
    logic          done_d, load_go_d, busy_d;
    logic [31:0]   vers_d;

    always_comb begin
        state_d  = state;
        sel_d    = sel;
        cnt_d    = cnt + CW'(1);
        dec_d    = decouple_o;
        rprst_d  = rp_rst_o;
        status_d = status_o;
        vers_d   = last_vers_o;
        done_d   = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (req_i) begin
                    sel_d            = req_sel_i;
                    state_d          = S_DECOUPLE;
                    dec_d[req_sel_i] = 1'b1;
                end
            end
            S_DECOUPLE: begin
                if (cnt == Q_LAST) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (load_err_i || (!load_done_i && cnt == TO_LAST)) begin
                    // Failed RP stays isolated and in reset until a good swap
                    state_d      = S_IDLE;
                    done_d       = 1'b1;
                    status_d     = load_err_i ? 2'b01 : 2'b10;
                    dec_d[sel]   = 1'b1;
                    rprst_d[sel] = 1'b1;
                end else if (load_done_i) begin
                    state_d      = S_RESET;
                    cnt_d        = '0;
                    dec_d[sel]   = 1'b1;
                    rprst_d[sel] = 1'b1;
                end
            end
            S_RESET: begin
                if (cnt == R_LAST) begin
                    state_d      = S_RECOUPLE;
                    rprst_d[sel] = 1'b0;
                end
            end
            S_RECOUPLE: begin
                state_d    = S_CHECK;
                cnt_d      = '0;
                dec_d[sel] = 1'b0;
            end
            S_CHECK: begin
                if (cnt == C_LAST) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    vers_d   = version_i;
                    status_d = (version_i == 32'h0000_0000 ||
                                version_i == 32'hFFFF_FFFF) ? 2'b11 : 2'b00;
                end
            end
            default: state_d = S_IDLE;
        endcase
        load_go_d = (state_d == S_LOAD);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            sel         <= 1'b0;
            cnt         <= '0;
            load_go_o   <= 1'b0;
            decouple_o  <= 2'b00;
            rp_rst_o    <= 2'b00;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            status_o    <= 2'b00;
            last_vers_o <= 32'h0;
        end else begin
            state       <= state_d;
            sel         <= sel_d;
            cnt         <= cnt_d;
            load_go_o   <= load_go_d;
            decouple_o  <= dec_d;
            rp_rst_o    <= rprst_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            status_o    <= status_d;
            last_vers_o <= vers_d;
        end
    end

endmodule
